// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between NUM_REQ requesters.
// Optional per-requester grant counters on the grant_cnt port when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic                           mem_ready,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]          grant_cnt
`endif
);

    localparam int TAG_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        CMD  = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] win;
    logic [TAG_W-1:0] cmd_tag;
    logic [TAG_W-1:0] rsp_tag;
    logic             accept;
    logic             rsp_pending;
    int unsigned      idx;

    // Winner is the first valid requester at or above the pointer, wrapping.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        req_ready = '0;
        win       = '0;
        accept    = 1'b0;
        idx       = 0;
        if (state == IDLE || mem_ready) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr) + k) % NUM_REQ;
                if (!accept && req_valid[idx]) begin
                    accept = 1'b1;
                    win    = TAG_W'(idx);
                end
            end
        end
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CMD;
            CMD:     if (mem_ready) next_state = accept ? CMD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= next_state;
        end
    end

    assign mem_en = (state == CMD);

    // Command fields only change on acceptance, so they stay bit-exact while mem_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cmd_tag   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            mem_wr    <= req_wr[win];
            mem_addr  <= req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata <= req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            cmd_tag   <= win;
            ptr       <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pending <= 1'b0;
            rsp_tag     <= '0;
        end else begin
            rsp_pending <= mem_en & mem_ready & ~mem_wr;
            rsp_tag     <= cmd_tag;
        end
    end

    // Read data is passed straight through from the memory during the response cycle.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (rsp_pending) begin
            rsp_valid[rsp_tag] = 1'b1;
            rsp_rdata          = mem_rdata;
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && int'(win) == i && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
